// File: rtl/dot_result_collect_if.sv
// dot_result_collect_if
//   Bundles the dot-result input bus, the conv output stream and the FC
//   result/status signals of dot_result_collect.
//   master : environment side (drives dot_*, conv_rdy, fc_clr)
//   slave  : collector side (drives conv_*, fc_*, ovf, fifo_cnt)
interface dot_result_collect_if #(
  parameter int SUM_WIDTH  = 21,
  parameter int ACC_WIDTH  = 28,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                        dot_vld;
  logic signed [SUM_WIDTH-1:0] dot;
  logic [6:0]                  dot_tag;
  logic [7:0]                  conv_data;
  logic                        conv_vld;
  logic                        conv_rdy;
  logic signed [ACC_WIDTH-1:0] fc_sum;
  logic                        fc_vld;
  logic                        fc_clr;
  logic                        ovf;
  logic [CNT_W-1:0]            fifo_cnt;

  modport master (
    output dot_vld, dot, dot_tag, conv_rdy, fc_clr,
    input  conv_data, conv_vld, fc_sum, fc_vld, ovf, fifo_cnt
  );

  modport slave (
    input  dot_vld, dot, dot_tag, conv_rdy, fc_clr,
    output conv_data, conv_vld, fc_sum, fc_vld, ovf, fifo_cnt
  );
endinterface

// File: rtl/dot_result_collect.sv
// dot_result_collect
//   Consumer end of the shared 9-tap dot-product datapath. Each dot result
//   arrives with its schedule tag:
//     tag 0..66   -> conv result: shift, ReLU, clamp to 0..127, queue in FIFO
//     tag 67      -> FC partial: accumulate FC_BEATS partials, pulse fc_vld
//     tag 68..127 -> ignored
//   Ports:
//     clk, rst_n : clock, async active-low reset
//     bus.dot_vld/dot/dot_tag   : dot result input (no back-pressure)
//     bus.conv_data/vld/rdy     : requantized conv stream (FIFO head)
//     bus.fc_sum/fc_vld/fc_clr  : FC sum, completion pulse, abort
//     bus.ovf                   : sticky conv-drop flag
//     bus.fifo_cnt              : FIFO occupancy
//
//   FC state | meaning
//   ---------+-----------------------------------------------
//   IDLE     | no partial in progress, acc == 0, beat cnt == 0
//   ACCUM    | at least one FC beat accumulated, more expected
module dot_result_collect #(
  parameter int SUM_WIDTH  = 21,
  parameter int ACC_WIDTH  = 28,
  parameter int SHIFT      = 7,
  parameter int FIFO_DEPTH = 4,
  parameter int FC_BEATS   = 10
) (
  input logic                  clk,
  input logic                  rst_n,
  dot_result_collect_if.slave  bus
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int BW = (FC_BEATS > 1) ? $clog2(FC_BEATS) : 1;

  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} fc_state_t;

  // tag decode
  logic push_req;
  logic fc_beat;
  assign push_req = bus.dot_vld && (bus.dot_tag <= 7'd66);
  assign fc_beat  = bus.dot_vld && (bus.dot_tag == 7'd67);

  // requantization
  logic signed [SUM_WIDTH-1:0] shr;
  logic [7:0]                  conv_q;
  always_comb begin
    shr = bus.dot >>> SHIFT;
    if (shr[SUM_WIDTH-1])
      conv_q = 8'd0;
    else if (|shr[SUM_WIDTH-2:7])
      conv_q = 8'd127;
    else
      conv_q = {1'b0, shr[6:0]};
  end

  // conv FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          ovf_q;
  logic          full;
  logic          empty;
  logic          pop;
  logic          push;

  assign full  = (cnt == CW'(FIFO_DEPTH));
  assign empty = (cnt == '0);
  assign pop   = !empty && bus.conv_rdy;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push  = push_req && (!full || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'd0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= conv_q;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)
        cnt <= cnt + CW'(1);
      else if (pop && !push)
        cnt <= cnt - CW'(1);
      if (push_req && full && !pop)
        ovf_q <= 1'b1;
    end
  end

  assign bus.conv_data = mem[rd_ptr];
  assign bus.conv_vld  = !empty;
  assign bus.fifo_cnt  = cnt;
  assign bus.ovf       = ovf_q;

  // FC accumulation
  fc_state_t                   fc_state;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] acc_base;
  logic signed [ACC_WIDTH-1:0] acc_next;
  logic [BW-1:0]               beat;
  logic signed [ACC_WIDTH-1:0] fc_sum_q;
  logic                        fc_vld_q;
  logic                        fc_last;

  // acc is already zero in IDLE; gating on state keeps a stray value from
  // ever leaking into a fresh sum
  assign acc_base = (fc_state == IDLE) ? '0 : acc;
  assign acc_next = acc_base + {{(ACC_WIDTH-SUM_WIDTH){bus.dot[SUM_WIDTH-1]}}, bus.dot};
  assign fc_last  = (beat == BW'(FC_BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc_state <= IDLE;
      acc      <= '0;
      beat     <= '0;
      fc_sum_q <= '0;
      fc_vld_q <= 1'b0;
    end else begin
      fc_vld_q <= 1'b0;
      if (bus.fc_clr) begin
        // abort wins over a coincident beat
        fc_state <= IDLE;
        acc      <= '0;
        beat     <= '0;
      end else if (fc_beat) begin
        if (fc_last) begin
          fc_sum_q <= acc_next;
          fc_vld_q <= 1'b1;
          fc_state <= IDLE;
          acc      <= '0;
          beat     <= '0;
        end else begin
          fc_state <= ACCUM;
          acc      <= acc_next;
          beat     <= beat + BW'(1);
        end
      end
    end
  end

  assign bus.fc_sum = fc_sum_q;
  assign bus.fc_vld = fc_vld_q;
endmodule

// File: tb/tb_dot_result_collect.sv
// tb_dot_result_collect
//   Directed bench for dot_result_collect. Inputs change 1 time unit after
//   a rising edge, outputs are sampled at the same offset.
module tb_dot_result_collect;
  localparam int SUM_WIDTH  = 21;
  localparam int ACC_WIDTH  = 28;
  localparam int FIFO_DEPTH = 4;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  dot_result_collect_if #(
    .SUM_WIDTH(SUM_WIDTH), .ACC_WIDTH(ACC_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)
  ) bus ();

  dot_result_collect #(
    .SUM_WIDTH(SUM_WIDTH), .ACC_WIDTH(ACC_WIDTH), .SHIFT(7),
    .FIFO_DEPTH(FIFO_DEPTH), .FC_BEATS(10)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int v, input int tag);
    bus.dot     = SUM_WIDTH'(v);
    bus.dot_tag = 7'(tag);
    bus.dot_vld = 1'b1;
    cycle();
    bus.dot_vld = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (bus.conv_vld !== 1'b0) begin bad++; $display("FAIL reset_conv_vld got=%b want=0", bus.conv_vld); end
    total++; if (bus.conv_data !== 8'd0) begin bad++; $display("FAIL reset_conv_data got=%0d want=0", bus.conv_data); end
    total++; if (bus.fifo_cnt !== 3'd0) begin bad++; $display("FAIL reset_fifo_cnt got=%0d want=0", bus.fifo_cnt); end
    total++; if (bus.fc_sum !== 28'sd0) begin bad++; $display("FAIL reset_fc_sum got=%0d want=0", bus.fc_sum); end
    total++; if (bus.fc_vld !== 1'b0) begin bad++; $display("FAIL reset_fc_vld got=%b want=0", bus.fc_vld); end
    total++; if (bus.ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", bus.ovf); end
  endtask

  task automatic test_first_conv();
    bus.conv_rdy = 1'b1;
    send(1000, 5);
    total++; if (bus.conv_vld !== 1'b1) begin bad++; $display("FAIL first_vld got=%b want=1", bus.conv_vld); end
    total++; if (bus.conv_data !== 8'd7) begin bad++; $display("FAIL first_data got=%0d want=7", bus.conv_data); end
    cycle();
    total++; if (bus.conv_vld !== 1'b0) begin bad++; $display("FAIL first_drain got=%b want=0", bus.conv_vld); end
  endtask

  task automatic test_clamp();
    int vin [4]  = '{-500, 20000, 16383, 127};
    int vexp [4] = '{0, 127, 127, 0};
    bus.conv_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(vin[i], 10 + i);
      total++;
      if (bus.conv_vld !== 1'b1 || bus.conv_data !== 8'(vexp[i])) begin
        bad++; $display("FAIL clamp_%0d got vld=%b data=%0d want vld=1 data=%0d", vin[i], bus.conv_vld, bus.conv_data, vexp[i]);
      end
      cycle();
    end
  endtask

  task automatic test_overflow();
    bus.conv_rdy = 1'b0;
    for (int k = 1; k <= 4; k++) send(128 * k, 20 + k);
    total++; if (bus.fifo_cnt !== 3'd4 || bus.ovf !== 1'b0) begin bad++; $display("FAIL ovf_fill got cnt=%0d ovf=%b want cnt=4 ovf=0", bus.fifo_cnt, bus.ovf); end
    send(640, 25);
    total++; if (bus.fifo_cnt !== 3'd4 || bus.ovf !== 1'b1) begin bad++; $display("FAIL ovf_drop got cnt=%0d ovf=%b want cnt=4 ovf=1", bus.fifo_cnt, bus.ovf); end
    bus.conv_rdy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      total++; if (bus.conv_data !== 8'(k)) begin bad++; $display("FAIL ovf_drain got=%0d want=%0d", bus.conv_data, k); end
      cycle();
    end
    total++; if (bus.fifo_cnt !== 3'd0) begin bad++; $display("FAIL ovf_empty got=%0d want=0", bus.fifo_cnt); end
    bus.conv_rdy = 1'b0;
    for (int k = 1; k <= 4; k++) send(1280 * k, 30);
    bus.conv_rdy = 1'b1;
    send(6400, 31);
    total++; if (bus.fifo_cnt !== 3'd4 || bus.ovf !== 1'b1 || bus.conv_data !== 8'd20) begin
      bad++; $display("FAIL full_pushpop got cnt=%0d ovf=%b head=%0d want cnt=4 ovf=1 head=20", bus.fifo_cnt, bus.ovf, bus.conv_data);
    end
    for (int k = 2; k <= 5; k++) begin
      total++; if (bus.conv_data !== 8'(10 * k)) begin bad++; $display("FAIL full_drain got=%0d want=%0d", bus.conv_data, 10 * k); end
      cycle();
    end
  endtask

  task automatic test_fc_sum();
    bus.conv_rdy = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(128 * (i + 1), 3);
      total++; if (bus.conv_vld !== 1'b1 || bus.conv_data !== 8'(i + 1) || bus.fifo_cnt !== 3'd1) begin
        bad++; $display("FAIL fc_conv_%0d got vld=%b data=%0d cnt=%0d want vld=1 data=%0d cnt=1", i, bus.conv_vld, bus.conv_data, bus.fifo_cnt, i + 1);
      end
      send(100, 67);
      total++; if (bus.fc_vld !== (i == 9)) begin bad++; $display("FAIL fc_pulse_%0d got=%b want=%b", i, bus.fc_vld, (i == 9)); end
    end
    total++; if (bus.fc_sum !== 28'sd1000) begin bad++; $display("FAIL fc_sum_1000 got=%0d want=1000", bus.fc_sum); end
    cycle();
    total++; if (bus.fc_vld !== 1'b0 || bus.fc_sum !== 28'sd1000) begin bad++; $display("FAIL fc_hold got vld=%b sum=%0d want vld=0 sum=1000", bus.fc_vld, bus.fc_sum); end
    for (int i = 0; i < 10; i++) send(-3, 67);
    total++; if (bus.fc_vld !== 1'b1 || bus.fc_sum !== -28'sd30) begin bad++; $display("FAIL fc_sum_neg got vld=%b sum=%0d want vld=1 sum=-30", bus.fc_vld, bus.fc_sum); end
  endtask

  task automatic test_clr_tag68();
    for (int i = 0; i < 4; i++) send(50, 67);
    bus.fc_clr = 1'b1;
    cycle();
    bus.fc_clr = 1'b0;
    total++; if (bus.fc_vld !== 1'b0 || bus.fc_sum !== -28'sd30) begin bad++; $display("FAIL clr_hold got vld=%b sum=%0d want vld=0 sum=-30", bus.fc_vld, bus.fc_sum); end
    for (int i = 0; i < 5; i++) send(1, 67);
    for (int i = 0; i < 3; i++) send(999, 68);
    total++; if (bus.fifo_cnt !== 3'd0 || bus.fc_vld !== 1'b0) begin bad++; $display("FAIL tag68 got cnt=%0d fc_vld=%b want cnt=0 fc_vld=0", bus.fifo_cnt, bus.fc_vld); end
    for (int i = 0; i < 5; i++) send(1, 67);
    total++; if (bus.fc_vld !== 1'b1 || bus.fc_sum !== 28'sd10) begin bad++; $display("FAIL clr_sum got vld=%b sum=%0d want vld=1 sum=10", bus.fc_vld, bus.fc_sum); end
    send(5, 67);
    send(5, 67);
    bus.fc_clr = 1'b1;
    send(100, 67);
    bus.fc_clr = 1'b0;
    for (int i = 0; i < 9; i++) send(2, 67);
    total++; if (bus.fc_vld !== 1'b0) begin bad++; $display("FAIL clr_beat_early got=%b want=0", bus.fc_vld); end
    send(2, 67);
    total++; if (bus.fc_vld !== 1'b1 || bus.fc_sum !== 28'sd20) begin bad++; $display("FAIL clr_beat_sum got vld=%b sum=%0d want vld=1 sum=20", bus.fc_vld, bus.fc_sum); end
  endtask

  task automatic test_reset_mid();
    bus.conv_rdy = 1'b0;
    send(256, 1);
    send(384, 2);
    for (int i = 0; i < 3; i++) send(9, 67);
    total++; if (bus.fifo_cnt !== 3'd2) begin bad++; $display("FAIL mid_pending got=%0d want=2", bus.fifo_cnt); end
    #3;
    rst_n = 1'b0;
    #1;
    total++; if (bus.conv_vld !== 1'b0 || bus.fifo_cnt !== 3'd0 || bus.conv_data !== 8'd0) begin
      bad++; $display("FAIL mid_fifo got vld=%b cnt=%0d data=%0d want 0 0 0", bus.conv_vld, bus.fifo_cnt, bus.conv_data);
    end
    total++; if (bus.fc_sum !== 28'sd0 || bus.fc_vld !== 1'b0 || bus.ovf !== 1'b0) begin
      bad++; $display("FAIL mid_fc got sum=%0d vld=%b ovf=%b want 0 0 0", bus.fc_sum, bus.fc_vld, bus.ovf);
    end
    cycle();
    rst_n = 1'b1;
    cycle();
    bus.conv_rdy = 1'b1;
    for (int i = 0; i < 10; i++) send(7, 67);
    total++; if (bus.fc_vld !== 1'b1 || bus.fc_sum !== 28'sd70) begin bad++; $display("FAIL mid_after got vld=%b sum=%0d want vld=1 sum=70", bus.fc_vld, bus.fc_sum); end
    total++; if (bus.conv_vld !== 1'b0) begin bad++; $display("FAIL mid_conv got=%b want=0", bus.conv_vld); end
  endtask

  initial begin
    total        = 0;
    bad          = 0;
    rst_n        = 1'b0;
    bus.dot_vld  = 1'b0;
    bus.dot      = '0;
    bus.dot_tag  = '0;
    bus.conv_rdy = 1'b0;
    bus.fc_clr   = 1'b0;
    cycle();
    cycle();
    test_reset();
    rst_n = 1'b1;
    cycle();
    test_reset();
    test_first_conv();
    test_clamp();
    test_overflow();
    test_fc_sum();
    test_clr_tag68();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dot_result_collect.md
Name: dot_result_collect

Overview:
- Consumer end of the shared 9-tap dot-product datapath. It receives each dot result with the schedule counter value (tag) that the operand side issued for it.
- Tags 0..66 are convolution results. Each one is requantized (arithmetic shift, ReLU, clamp) and queued in a small FIFO for the feature-map writer, with a valid/ready handshake.
- Tag 67 is a fully-connected partial. FC partials are accumulated over FC_BEATS results and emitted as one sum pulse.
- Sits directly downstream of the dot-product unit in the calc block.

Parameters:
- SUM_WIDTH, 21, width of the signed dot input.
- ACC_WIDTH, 28, width of the signed FC accumulator. Must be >= SUM_WIDTH + clog2(FC_BEATS).
- SHIFT, 7, arithmetic right shift applied to conv results before clamping.
- FIFO_DEPTH, 4, conv output FIFO entries (power of two, >= 2).
- FC_BEATS, 10, number of FC partials summed into one fc_sum.

Ports:
- clk, in, 1: single clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- dot_vld, in, 1: dot and dot_tag valid this cycle. No back-pressure is possible upstream.
- dot, in, SUM_WIDTH: signed two's-complement dot result.
- dot_tag, in, 7: schedule counter value 0..68 carried alongside dot.
- conv_data, out, 8: requantized conv value, 0..127, at the FIFO head.
- conv_vld, out, 1: FIFO not empty.
- conv_rdy, in, 1: downstream accepts conv_data this cycle.
- fc_sum, out, ACC_WIDTH: completed FC sum. Held until the next completion.
- fc_vld, out, 1: one-cycle pulse when fc_sum updates.
- fc_clr, in, 1: synchronous abort of the FC accumulation in progress.
- ovf, out, 1: sticky flag, set when a conv result is dropped because the FIFO is full. Cleared only by reset.
- fifo_cnt, out, clog2(FIFO_DEPTH)+1: current FIFO occupancy.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty, conv_vld=0, conv_data=0.
  - fc_sum=0, fc_vld=0, ovf=0, fifo_cnt=0.
  - Accumulator and beat counter = 0.
- Tag decode, only when dot_vld=1:
  - dot_tag 0..66: conv push.
  - dot_tag 67: FC beat.
  - dot_tag 68..127: dropped silently; no state changes.
- Conv requant (combinational on input):
  - r = dot >>> SHIFT (sign-preserving).
  - r < 0 gives 0; r > 127 gives 127; otherwise the low 8 bits of r.
- Conv FIFO:
  - Push is written at the clock edge ending the dot_vld cycle, so conv_vld rises the next cycle when the FIFO was empty. Latency is 1.
  - Pop occurs when conv_vld && conv_rdy. conv_data always shows the head entry and is registered/stable while conv_vld=1 and conv_rdy=0.
  - Push while full with a pop in the same cycle is accepted; fifo_cnt is unchanged.
  - Push while full with no pop: the result is dropped, ovf is set to 1 on that edge, and FIFO contents are unchanged.
  - Pop while empty is ignored. Pointers wrap modulo FIFO_DEPTH.
- FC path, state IDLE/ACCUM, tracked by beat counter b (0..FC_BEATS-1):
  - On an FC beat: acc <= acc + sext(dot) and b <= b+1; the state becomes ACCUM.
  - When the beat arrives with b == FC_BEATS-1:
    - fc_sum <= acc + sext(dot), and fc_vld=1 the next cycle for exactly one cycle.
    - acc <= 0, b <= 0, state returns to IDLE.
  - The accumulator wraps modulo 2^ACC_WIDTH. The parameter constraint prevents wrap in legal use.
  - fc_clr=1: acc <= 0 and b <= 0; fc_sum is unchanged and there is no fc_vld.
  - fc_clr coinciding with an FC beat: the clear wins and the beat is discarded.
- Conv and FC paths are independent; a tag change never disturbs the other path's state.
- Reset asserted mid-operation discards all FIFO contents and the partial FC sum immediately.

Test Plan:
- Reset, then dot_vld with dot=1000, tag=5, conv_rdy=1 -> next cycle conv_vld=1, conv_data=7; the following cycle conv_vld=0.
- Clamp checks with conv_rdy=1: dot=-500 -> 0; dot=20000 -> 127; dot=16383 -> 127; dot=127 -> 0. Each appears one cycle after input.
- conv_rdy=0 with 5 conv pushes (dot=128,256,384,512,640) -> fifo_cnt=4 and ovf=1 after the 5th. Raising conv_rdy then drains 1,2,3,4 in order. A later push+pop while full leaves fifo_cnt=4 and ovf stays 1.
- FC sum: 10 beats, tag=67, dot=100, interleaved with tag=3 conv pushes -> fc_vld single pulse one cycle after the 10th beat, fc_sum=1000. Conv outputs are unaffected. A second run of 10 beats of dot=-3 gives fc_sum=-30.
- Tag 68 and fc_clr: 4 FC beats of dot=50, then fc_clr, then 10 beats of dot=1 -> fc_sum=10. Beats sent with tag=68 cause no FIFO or accumulator change.
- Reset mid-stream: 2 FIFO entries plus 3 FC beats pending, pulse rst_n low asynchronously -> all outputs return to reset values at once. The next 10 FC beats of dot=7 give fc_sum=70.
